i2s_transmitter: RTL and testbench

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

---
 rtl/audio_pkg.sv | 19 +
 rtl/i2s_bclk_gen.sv | 44 ++++
 rtl/i2s_transmitter.sv | 78 +++++++
 tb/tb_i2s_transmitter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants: frame geometry and I2S data slot windows.
package audio_pkg;
    localparam int SAMPLE_WIDTH_DEF = 16;
    localparam int FRAME_SLOTS      = 64;
    localparam int HP_COUNT         = 2 * FRAME_SLOTS;
    localparam int SLOT_W           = $clog2(FRAME_SLOTS);
    localparam int HP_W             = $clog2(HP_COUNT);

    localparam logic [SLOT_W-1:0] LEFT_FIRST  = 6'd1;
    localparam logic [SLOT_W-1:0] LEFT_LAST   = 6'd16;
    localparam logic [SLOT_W-1:0] RIGHT_FIRST = 6'd33;
    localparam logic [SLOT_W-1:0] RIGHT_LAST  = 6'd48;

    function automatic logic in_window(input logic [SLOT_W-1:0] slot,
                                       input logic [SLOT_W-1:0] first,
                                       input logic [SLOT_W-1:0] last);
        return (slot >= first) && (slot <= last);
    endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// Frame timing: clk divider, half-period counter, and registered bclk/lrclk/new_frame.
module i2s_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic            clk,
    input  logic            reset,
    output logic            tick,
    output logic [HP_W-1:0] hp,
    output logic            bclk,
    output logic            lrclk,
    output logic            new_frame
);
    localparam int              DIV_W    = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(HP_COUNT - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div       <= '0;
            hp        <= '0;
            new_frame <= 1'b0;
        end else begin
            new_frame <= 1'b0;
            if (tick) begin
                div <= '0;
                hp  <= hp + HP_W'(1);
                // Pulse lands on the first cycle of hp==0; none on reset release.
                new_frame <= (hp == HP_LAST);
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Both are bits of the hp flop, so they only move when hp does.
    assign bclk  = hp[0];
    assign lrclk = hp[HP_W-1];
endmodule

// File: rtl/i2s_transmitter.sv
// I2S mono transmitter: latches one sample per frame and shifts it MSB-first into both channels.
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int BCLK_DIV     = 16,
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    mute,
    output logic                    new_frame,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata
);
    localparam int              IDX_W   = $clog2(SAMPLE_WIDTH);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HP_COUNT - 1);

    logic                    tick;
    logic [HP_W-1:0]         hp;
    logic [HP_W-1:0]         hp_nxt;
    logic [SLOT_W-1:0]       slot_nxt;
    logic [SLOT_W-1:0]       offset;
    logic [IDX_W-1:0]        idx;
    logic                    started;
    logic                    latch;
    logic                    in_data;
    logic [SAMPLE_WIDTH-1:0] shadow_sample;
    logic                    shadow_mute;
    logic [SAMPLE_WIDTH-1:0] eff;

    i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .hp        (hp),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .new_frame (new_frame)
    );

    // The latch edge also opens slot 1, so the MSB is taken from the value being latched.
    always_comb begin
        hp_nxt   = hp + HP_W'(1);
        slot_nxt = hp_nxt[HP_W-1:1];
        latch    = tick && started && (hp == HP_W'(1));
        if (latch)
            eff = mute ? '0 : sample_in;
        else
            eff = shadow_mute ? '0 : shadow_sample;
        offset  = in_window(slot_nxt, RIGHT_FIRST, RIGHT_LAST) ? slot_nxt - RIGHT_FIRST
                                                               : slot_nxt - LEFT_FIRST;
        in_data = (in_window(slot_nxt, LEFT_FIRST, LEFT_LAST) ||
                   in_window(slot_nxt, RIGHT_FIRST, RIGHT_LAST)) &&
                  (offset < SLOT_W'(SAMPLE_WIDTH));
        idx     = IDX_W'(SAMPLE_WIDTH - 1) - offset[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started       <= 1'b0;
            shadow_sample <= '0;
            shadow_mute   <= 1'b0;
            sdata         <= 1'b0;
        end else begin
            // The partial frame after reset has no pulse and carries only zeros.
            if (tick && (hp == HP_LAST))
                started <= 1'b1;
            if (latch) begin
                shadow_sample <= sample_in;
                shadow_mute   <= mute;
            end
            if (tick && hp[0])
                sdata <= started && in_data && eff[idx];
        end
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: frame timing, data slots, latch point, mute, resets, slow divider.
module tb_i2s_transmitter;
    logic        clk;
    logic        reset;
    logic        rst255;
    logic [15:0] sample_in;
    logic        mute;
    logic        new_frame, bclk, lrclk, sdata;
    logic        new_frame255, bclk255, lrclk255, sdata255;

    int checks;
    int failures;

    i2s_transmitter #(.BCLK_DIV(2), .SAMPLE_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .mute(mute),
        .new_frame(new_frame), .bclk(bclk), .lrclk(lrclk), .sdata(sdata)
    );

    i2s_transmitter #(.BCLK_DIV(255), .SAMPLE_WIDTH(16)) dut255 (
        .clk(clk), .reset(rst255), .sample_in(sample_in), .mute(mute),
        .new_frame(new_frame255), .bclk(bclk255), .lrclk(lrclk255), .sdata(sdata255)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame: slot s occupies bit 63-s; data in slots 1-16 and 33-48.
    function automatic logic [63:0] model_frame(input logic [15:0] v, input logic m);
        logic [15:0] d;
        d = m ? 16'h0 : v;
        return {1'b0, d, 16'h0, d, 15'h0};
    endfunction

    // Waits for a frame start, then records sdata in every slot at the bclk rising
    // edge and counts timing violations over the 256 cycles of the frame.
    task automatic run_frame(input int chg_at, input logic [15:0] chg_s, input logic chg_m,
                             output logic [63:0] sd, output int serr, output bit found);
        logic prev;
        int   h;
        found = 0;
        serr  = 0;
        sd    = '0;
        prev  = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk); #1;
            if (new_frame === 1'b1) found = 1;
        end
        if (!found) return;
        for (int c = 0; c < 256; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            h = c / 2;
            if (new_frame !== (c == 0)) serr++;
            if (bclk !== ((h % 2) == 1)) serr++;
            if (lrclk !== (h >= 64)) serr++;
            if ((c % 4) != 0 && sdata !== prev) serr++;
            if ((c % 4) == 2) sd[63 - c / 4] = sdata;
            prev = sdata;
            if (c == chg_at) begin
                sample_in = chg_s;
                mute      = chg_m;
            end
        end
    endtask

    task automatic test_reset();
        int first, second, highs, dirty;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({new_frame, bclk, lrclk, sdata} !== 4'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000", {new_frame, bclk, lrclk, sdata});
        end
        first = 0; second = 0; highs = 0; dirty = 0;
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            if (new_frame === 1'b1) begin
                highs++;
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
            if (first == 0 && sdata !== 1'b0) dirty++;
        end
        checks++;
        if (first != 256) begin
            failures++;
            $display("FAIL first_pulse: got cycle %0d expected 256", first);
        end
        checks++;
        if (second != 512) begin
            failures++;
            $display("FAIL second_pulse: got cycle %0d expected 512", second);
        end
        checks++;
        if (highs != 2) begin
            failures++;
            $display("FAIL pulse_width: got %0d high cycles expected 2", highs);
        end
        checks++;
        if (dirty != 0) begin
            failures++;
            $display("FAIL partial_frame_zero: got %0d nonzero cycles expected 0", dirty);
        end
    endtask

    task automatic test_data();
        logic [63:0] sd;
        int          serr;
        bit          found;
        logic [15:0] v;
        v = 16'hA5C3;
        sample_in = v;
        mute = 1'b0;
        run_frame(-1, 16'h0, 1'b0, sd, serr, found);
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL data_frame_found: got none expected pulse");
        end
        checks++;
        if (serr != 0) begin
            failures++;
            $display("FAIL data_timing: got %0d violations expected 0", serr);
        end
        checks++;
        if (sd[62:47] !== v) begin
            failures++;
            $display("FAIL data_left: got %h expected %h", sd[62:47], v);
        end
        checks++;
        if (sd[30:15] !== v) begin
            failures++;
            $display("FAIL data_right: got %h expected %h", sd[30:15], v);
        end
        checks++;
        if (sd[62] !== v[15] || sd[30] !== v[15]) begin
            failures++;
            $display("FAIL data_msb_slot: got %b%b expected %b%b", sd[62], sd[30], v[15], v[15]);
        end
        checks++;
        if (sd[63] !== 1'b0 || sd[46:31] !== 16'h0 || sd[14:0] !== 15'h0) begin
            failures++;
            $display("FAIL data_idle_slots: got %h expected %h", sd, model_frame(v, 1'b0));
        end
    endtask

    task automatic test_latch();
        logic [63:0] sd;
        int          serr;
        bit          found;
        sample_in = 16'h1234;
        mute = 1'b0;
        run_frame(4, 16'hFFFF, 1'b0, sd, serr, found);
        checks++;
        if (!found || serr != 0 || sd !== model_frame(16'h1234, 1'b0)) begin
            failures++;
            $display("FAIL latch_old: got %h err %0d expected %h", sd, serr, model_frame(16'h1234, 1'b0));
        end
        run_frame(-1, 16'h0, 1'b0, sd, serr, found);
        checks++;
        if (!found || serr != 0 || sd !== model_frame(16'hFFFF, 1'b0)) begin
            failures++;
            $display("FAIL latch_new: got %h err %0d expected %h", sd, serr, model_frame(16'hFFFF, 1'b0));
        end
    endtask

    task automatic test_mute();
        logic [63:0] sd;
        int          serr;
        bit          found;
        sample_in = 16'h7FFF;
        mute = 1'b1;
        run_frame(4, 16'h7FFF, 1'b0, sd, serr, found);
        checks++;
        if (!found || serr != 0 || sd !== 64'h0) begin
            failures++;
            $display("FAIL mute_frame: got %h err %0d expected 0", sd, serr);
        end
        run_frame(-1, 16'h0, 1'b0, sd, serr, found);
        checks++;
        if (!found || serr != 0 || sd !== model_frame(16'h7FFF, 1'b0)) begin
            failures++;
            $display("FAIL unmute_frame: got %h err %0d expected %h", sd, serr, model_frame(16'h7FFF, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [63:0] sd, exp;
        int          serr;
        bit          found;
        logic [15:0] cur_v, nxt_v;
        logic        cur_m, nxt_m;
        cur_v = 16'($urandom);
        cur_m = ($urandom_range(0, 3) == 0);
        sample_in = cur_v;
        mute = cur_m;
        for (int f = 0; f < 6; f++) begin
            nxt_v = 16'($urandom);
            nxt_m = ($urandom_range(0, 3) == 0);
            exp = model_frame(cur_v, cur_m);
            run_frame(int'($urandom_range(4, 250)), nxt_v, nxt_m, sd, serr, found);
            checks++;
            if (!found || serr != 0 || sd !== exp) begin
                failures++;
                $display("FAIL random_frame%0d: got %h err %0d expected %h", f, sd, serr, exp);
            end
            cur_v = nxt_v;
            cur_m = nxt_m;
        end
    endtask

    task automatic test_mid_reset();
        bit   found;
        int   first, dirty, held;
        logic [63:0] sd;
        int   serr;
        found = 0;
        sample_in = 16'hC0DE;
        mute = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(posedge clk); #1;
            if (new_frame === 1'b1) found = 1;
        end
        repeat (140) begin @(posedge clk); #1; end
        checks++;
        if (!found || lrclk !== 1'b1 || bclk !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_hp70: got lrclk %b bclk %b expected 1 0", lrclk, bclk);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({new_frame, bclk, lrclk, sdata} !== 4'b0) begin
            failures++;
            $display("FAIL async_reset: got %b expected 0000", {new_frame, bclk, lrclk, sdata});
        end
        held = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if ({new_frame, bclk, lrclk, sdata} !== 4'b0) held++;
        end
        checks++;
        if (held != 0) begin
            failures++;
            $display("FAIL reset_hold: got %0d active cycles expected 0", held);
        end
        first = 0; dirty = 0;
        @(negedge clk) reset = 1'b1;
        for (int k = 1; k <= 300 && first == 0; k++) begin
            @(posedge clk); #1;
            if (new_frame === 1'b1) first = k;
            else if (sdata !== 1'b0) dirty++;
        end
        checks++;
        if (first != 256 || dirty != 0) begin
            failures++;
            $display("FAIL restart_pulse: got cycle %0d dirty %0d expected 256 0", first, dirty);
        end
        // The pulse has just been consumed; the following frame must carry C0DE.
        run_frame(-1, 16'h0, 1'b0, sd, serr, found);
        checks++;
        if (!found || serr != 0 || sd !== model_frame(16'hC0DE, 1'b0)) begin
            failures++;
            $display("FAIL restart_data: got %h err %0d expected %h", sd, serr, model_frame(16'hC0DE, 1'b0));
        end
    endtask

    task automatic test_div255();
        int   first, rise1, rise2;
        logic prev;
        checks++;
        if ({new_frame255, bclk255, lrclk255, sdata255} !== 4'b0) begin
            failures++;
            $display("FAIL div255_reset: got %b expected 0000", {new_frame255, bclk255, lrclk255, sdata255});
        end
        first = 0;
        @(negedge clk) rst255 = 1'b1;
        for (int k = 1; k <= 33000 && first == 0; k++) begin
            @(posedge clk); #1;
            if (new_frame255 === 1'b1) first = k;
        end
        checks++;
        if (first != 32640) begin
            failures++;
            $display("FAIL div255_frame: got cycle %0d expected 32640", first);
        end
        rise1 = 0; rise2 = 0;
        prev = bclk255;
        for (int k = 1; k <= 1200 && rise2 == 0; k++) begin
            @(posedge clk); #1;
            if (bclk255 === 1'b1 && prev === 1'b0) begin
                if (rise1 == 0) rise1 = k;
                else rise2 = k;
            end
            prev = bclk255;
        end
        checks++;
        if (rise1 != 255) begin
            failures++;
            $display("FAIL div255_half: got %0d expected 255", rise1);
        end
        checks++;
        if (rise2 - rise1 != 510) begin
            failures++;
            $display("FAIL div255_period: got %0d expected 510", rise2 - rise1);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        rst255    = 1'b0;
        sample_in = 16'hBEEF;
        mute      = 1'b0;
        test_reset();
        test_data();
        test_latch();
        test_mute();
        test_random();
        test_mid_reset();
        test_div255();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
